// File: rtl/ws2812b_frame_feeder_if.sv
// Framebuffer read port and bitstream handoff between the frame feeder and its neighbours.
interface ws2812b_frame_feeder_if #(
  parameter int unsigned STRIPECOUNT = 2,
  parameter int unsigned ADDR_WIDTH  = 8
);
  logic                        mem_rd_en;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [23:0]                 mem_rdata;
  logic                        bitstream_available;
  logic [STRIPECOUNT*24-1:0]   bitstream;
  logic                        bitstream_read;

  modport master (
    output mem_rd_en, mem_addr, bitstream_available, bitstream,
    input  mem_rdata, bitstream_read
  );

  modport slave (
    input  mem_rd_en, mem_addr, bitstream_available, bitstream,
    output mem_rdata, bitstream_read
  );
endinterface

// File: rtl/ws2812b_frame_feeder.sv
// Walks the framebuffer LED-major, reorders each pixel into LSB-first GRB lanes and
// offers one STRIPECOUNT-lane word per LED to the serializer, then waits out the latch gap.
module ws2812b_frame_feeder #(
  parameter int unsigned STRIPECOUNT     = 2,
  parameter int unsigned LEDS_PER_STRIPE = 8,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned LATCH_CYCLES    = 450
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  output logic busy,
  output logic frame_done,
  ws2812b_frame_feeder_if.master bus
);

  localparam int unsigned BS_W   = STRIPECOUNT * 24;
  localparam int unsigned LED_W  = $clog2(LEDS_PER_STRIPE + 1);
  localparam int unsigned LAT_W  = (LATCH_CYCLES > 0) ? $clog2(LATCH_CYCLES + 1) : 1;
  localparam int unsigned LANE_W = (STRIPECOUNT > 1) ? $clog2(STRIPECOUNT) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, OFFER, LATCH} state_t;

  state_t              state_q, state_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic [LANE_W-1:0]   stripe_q, stripe_d;
  logic [LANE_W-1:0]   cap_lane_q, cap_lane_d;
  logic                cap_v_q, cap_v_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                rd_en_q, rd_en_d;
  logic [BS_W-1:0]     asm_q, asm_d;
  logic [BS_W-1:0]     bs_q, bs_d;
  logic                avail_q, avail_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Lane bit k carries grb[23-k], so G[7] lands in bit 0 and leaves first.
  function automatic logic [23:0] to_lane(input logic [23:0] px);
    logic [23:0] grb;
    logic [23:0] lane;
    grb = {px[15:8], px[23:16], px[7:0]};
    for (int k = 0; k < 24; k++) lane[k] = grb[23-k];
    return lane;
  endfunction

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    stripe_d   = stripe_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    rd_en_d    = 1'b0;
    asm_d      = asm_q;
    bs_d       = bs_q;
    avail_d    = avail_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    // Read data returns one cycle after the RAM samples the strobe.
    cap_v_d    = rd_en_q;
    cap_lane_d = stripe_q;

    if (cap_v_q) asm_d[int'(cap_lane_q)*24 +: 24] = to_lane(bus.mem_rdata);

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d  = FETCH;
          busy_d   = 1'b1;
          led_d    = '0;
          stripe_d = '0;
          addr_d   = '0;
          rd_en_d  = 1'b1;
        end
      end
      FETCH: begin
        if (stripe_q == LANE_W'(STRIPECOUNT - 1)) begin
          state_d = CAPTURE;
        end else begin
          stripe_d = stripe_q + LANE_W'(1);
          addr_d   = addr_q + ADDR_WIDTH'(1);
          rd_en_d  = 1'b1;
        end
      end
      CAPTURE: state_d = OFFER;
      OFFER: begin
        // First OFFER cycle publishes the fully assembled word.
        if (!avail_q) begin
          bs_d    = asm_q;
          avail_d = 1'b1;
        end else if (bus.bitstream_read) begin
          avail_d = 1'b0;
          led_d   = led_q + LED_W'(1);
          if (led_q == LED_W'(LEDS_PER_STRIPE - 1)) begin
            state_d = LATCH;
            lat_d   = LAT_W'(LATCH_CYCLES);
          end else begin
            state_d  = FETCH;
            stripe_d = '0;
            addr_d   = addr_q + ADDR_WIDTH'(1);
            rd_en_d  = 1'b1;
          end
        end
      end
      LATCH: begin
        if (lat_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      led_q      <= '0;
      stripe_q   <= '0;
      cap_lane_q <= '0;
      cap_v_q    <= 1'b0;
      lat_q      <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      asm_q      <= '0;
      bs_q       <= '0;
      avail_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      stripe_q   <= stripe_d;
      cap_lane_q <= cap_lane_d;
      cap_v_q    <= cap_v_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      asm_q      <= asm_d;
      bs_q       <= bs_d;
      avail_q    <= avail_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy                    = busy_q;
  assign frame_done              = done_q;
  assign bus.mem_rd_en           = rd_en_q;
  assign bus.mem_addr            = addr_q;
  assign bus.bitstream_available = avail_q;
  assign bus.bitstream           = bs_q;

endmodule

// File: tb/tb_ws2812b_frame_feeder.sv
// Directed bench: STRIPECOUNT=2, LEDS_PER_STRIPE=3, LATCH_CYCLES=5 with a 1-cycle RAM model.
module tb_ws2812b_frame_feeder;

  logic clk;
  logic resetn;
  logic start;
  logic busy;
  logic frame_done;

  ws2812b_frame_feeder_if #(.STRIPECOUNT(2), .ADDR_WIDTH(8)) bus ();

  ws2812b_frame_feeder #(
    .STRIPECOUNT(2), .LEDS_PER_STRIPE(3), .ADDR_WIDTH(8), .LATCH_CYCLES(5)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .busy(busy), .frame_done(frame_done), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] mem [0:255];
  logic [7:0]  rd_log [0:255];
  int          rd_cnt = 0;

  // Synchronous-read framebuffer plus a log of every sampled address.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rdata  <= mem[bus.mem_addr];
      rd_log[rd_cnt] <= bus.mem_addr;
      rd_cnt         <= rd_cnt + 1;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    int  base;
    bit  ok;

    for (int i = 0; i < 256; i++) mem[i] = 24'h0;
    mem[0] = 24'hFF0000;
    mem[1] = 24'h0000A5;
    mem[2] = 24'h123456;
    mem[3] = 24'h008000;
    mem[4] = 24'h0000FF;
    mem[5] = 24'h010000;

    resetn = 1'b0;
    start  = 1'b1;
    bus.bitstream_read = 1'b0;
    repeat (3) tick();
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(frame_done), 64'd0);
    chk("rst_avail", 64'(bus.bitstream_available), 64'd0);
    chk("rst_rden",  64'(bus.mem_rd_en), 64'd0);
    chk("rst_reads", 64'(rd_cnt), 64'd0);

    resetn = 1'b1;
    start  = 1'b0;
    tick();
    tick();

    // Frame 1: latency, addressing and colour order
    base  = rd_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t0_busy", 64'(busy), 64'd1);
    chk("t0_rden", 64'(bus.mem_rd_en), 64'd1);
    chk("t0_addr", 64'(bus.mem_addr), 64'd0);
    tick();
    chk("t1_rden", 64'(bus.mem_rd_en), 64'd1);
    chk("t1_addr", 64'(bus.mem_addr), 64'd1);
    tick();
    chk("t2_rden", 64'(bus.mem_rd_en), 64'd0);
    tick();
    chk("t3_avail", 64'(bus.bitstream_available), 64'd0);
    tick();
    chk("t4_avail", 64'(bus.bitstream_available), 64'd1);
    chk("t4_bs",    64'(bus.bitstream), 64'h0000_A50000_00FF00);

    // Stall for 100 cycles with a start pulse that must be ignored
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      start = (i == 10);
      tick();
      if (!(bus.bitstream_available === 1'b1 && bus.bitstream === 48'hA50000_00FF00)) ok = 1'b0;
    end
    start = 1'b0;
    chk("stall_stable", 64'(ok), 64'd1);
    chk("stall_reads",  64'(rd_cnt - base), 64'd2);

    // Handoff 1, then a stray read pulse while nothing is offered
    bus.bitstream_read = 1'b1;
    tick();
    bus.bitstream_read = 1'b0;
    chk("h1_avail", 64'(bus.bitstream_available), 64'd0);
    chk("h1_rden",  64'(bus.mem_rd_en), 64'd1);
    chk("h1_addr",  64'(bus.mem_addr), 64'd2);
    tick();
    bus.bitstream_read = 1'b1;
    tick();
    bus.bitstream_read = 1'b0;
    tick();
    tick();
    chk("led1_avail", 64'(bus.bitstream_available), 64'd1);
    chk("led1_bs",    64'(bus.bitstream), 64'h0000_000001_6A482C);
    tick();
    tick();
    chk("led1_hold",  64'(bus.bitstream_available), 64'd1);

    // Handoff 2 -> last LED
    bus.bitstream_read = 1'b1;
    tick();
    bus.bitstream_read = 1'b0;
    repeat (4) tick();
    chk("led2_avail", 64'(bus.bitstream_available), 64'd1);
    chk("led2_bs",    64'(bus.bitstream), 64'h0000_008000_FF0000);

    // Final handoff and latch gap
    bus.bitstream_read = 1'b1;
    tick();
    bus.bitstream_read = 1'b0;
    chk("h3_avail", 64'(bus.bitstream_available), 64'd0);
    chk("h3_rden",  64'(bus.mem_rd_en), 64'd0);
    ok = (rd_cnt - base == 6);
    for (int i = 0; i < 6; i++) if (rd_log[base+i] !== 8'(i)) ok = 1'b0;
    chk("frame_addrs", 64'(ok), 64'd1);
    ok = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (frame_done !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    chk("latch_wait", 64'(ok), 64'd1);
    tick();
    chk("done_pulse", 64'(frame_done), 64'd1);
    chk("done_busy",  64'(busy), 64'd1);
    tick();
    chk("done_once",  64'(frame_done), 64'd0);
    chk("idle_busy",  64'(busy), 64'd0);

    // Mid-frame reset while the second word is offered
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bus.bitstream_read = 1'b1;
    tick();
    bus.bitstream_read = 1'b0;
    repeat (4) tick();
    chk("mr_avail_pre", 64'(bus.bitstream_available), 64'd1);
    resetn = 1'b0;
    tick();
    chk("mr_avail", 64'(bus.bitstream_available), 64'd0);
    chk("mr_busy",  64'(busy), 64'd0);
    tick();
    resetn = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (frame_done !== 1'b0 || bus.mem_rd_en !== 1'b0) ok = 1'b0;
    end
    chk("mr_no_done", 64'(ok), 64'd1);

    base  = rd_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mr_addr0", 64'(bus.mem_addr), 64'd0);
    repeat (4) tick();
    chk("mr_avail2", 64'(bus.bitstream_available), 64'd1);
    chk("mr_bs",     64'(bus.bitstream), 64'h0000_A50000_00FF00);
    ok = (rd_cnt - base == 2) && (rd_log[base] === 8'd0) && (rd_log[base+1] === 8'd1);
    chk("mr_addrs",  64'(ok), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
